// File: rtl/mem_rw_pkg.sv
// mem_rw_pkg: shared widths and FSM state encoding for the mem_rw controller
package mem_rw_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int CNT_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, ACK, WR_DATA, RD_DATA} state_t;
endpackage

// File: rtl/mem_rw_ram.sv
// mem_rw_ram: DEPTH x DATA_W byte store with async clear, sync write and registered read
module mem_rw_ram
  import mem_rw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/mem_rw_controller.sv
// mem_rw_controller: request/ack burst read/write front end for a 64x8 byte memory.
// Define MEM_RW_BOUND_CHECK_EN to reject bursts running past the top address (adds o_err).
module mem_rw_controller
  import mem_rw_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_req,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_done,
  input  logic              i_rd_req,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_done,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_ack,
  input  logic [CNT_W-1:0]  i_num_b
`ifdef MEM_RW_BOUND_CHECK_EN
  , output logic            o_err
`endif
);
  state_t state, next;
  logic [ADDR_W-1:0] base, ram_addr;
  logic [CNT_W-1:0] num, cnt;
  logic is_wr, req, start, reject, we, re, last, consume;
  assign req = i_wr_req || i_rd_req;
  assign ram_addr = base + ADDR_W'(cnt);
  assign last = (cnt + CNT_W'(1)) == num;
  assign consume = state == RD_DATA && o_rd_valid && i_rd_done;
  assign o_ack = state == ACK;
`ifdef MEM_RW_BOUND_CHECK_EN
  assign reject = ({1'b0, i_addr} + (ADDR_W+1)'(i_num_b)) > (ADDR_W+1)'(DEPTH);
`else
  assign reject = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    start = 1'b0;
    we = 1'b0;
    re = 1'b0;
    case (state)
      IDLE: begin
        start = req && !reject;
        next = start ? ACK : IDLE;
      end
      ACK: begin
        re = !is_wr;
        next = num == '0 ? IDLE : is_wr ? WR_DATA : RD_DATA;
      end
      WR_DATA: begin
        we = i_wr_valid && !o_wr_done;
        next = we && last ? IDLE : WR_DATA;
      end
      RD_DATA: begin
        re = !o_rd_valid;
        next = consume && last ? IDLE : RD_DATA;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      base <= '0;
      num <= '0;
      cnt <= '0;
      is_wr <= 1'b0;
      o_wr_done <= 1'b0;
      o_rd_valid <= 1'b0;
`ifdef MEM_RW_BOUND_CHECK_EN
      o_err <= 1'b0;
`endif
    end else begin
      o_wr_done <= we;
`ifdef MEM_RW_BOUND_CHECK_EN
      o_err <= state == IDLE && req && reject;
`endif
      // the read port refills on the cycle valid is low, so valid toggles around each consume
      o_rd_valid <= state == ACK ? !is_wr && num != '0 :
                    state == RD_DATA ? !(o_rd_valid && i_rd_done) : 1'b0;
      if (start) begin
        base <= i_addr;
        num <= i_num_b;
        is_wr <= i_wr_req;
        cnt <= '0;
      end else if (we || consume) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
  mem_rw_ram u_ram (
    .clk(i_clk),
    .rst(i_reset),
    .we(we),
    .re(re),
    .addr(ram_addr),
    .wdata(i_wr_data),
    .rdata(o_rd_data)
  );
endmodule

// File: tb/tb_mem_rw_controller.sv
// tb_mem_rw_controller: directed plus random bursts checked against a byte-array memory model
module tb_mem_rw_controller;
  logic i_clk = 0, i_reset = 0, i_wr_req = 0, i_wr_valid = 0, i_rd_req = 0, i_rd_done = 0;
  logic [7:0] i_wr_data = 0;
  logic [5:0] i_addr = 0;
  logic [3:0] i_num_b = 0;
  logic o_wr_done, o_rd_valid, o_ack;
  logic [7:0] o_rd_data;
  int checks = 0, errors = 0, ack_seen = 0, done_seen = 0;
  logic [7:0] model [64];

  mem_rw_controller dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr_req(i_wr_req), .i_wr_data(i_wr_data),
    .i_wr_valid(i_wr_valid), .o_wr_done(o_wr_done), .i_rd_req(i_rd_req),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_done(i_rd_done),
    .i_addr(i_addr), .o_ack(o_ack), .i_num_b(i_num_b)
  );

  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) begin
    ack_seen += int'(o_ack);
    done_seen += int'(o_wr_done);
  end

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input string tag, input bit rd);
    int n = 0;
    while ((rd ? o_rd_valid : o_wr_done) !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    check(tag, 32'(rd ? o_rd_valid : o_wr_done), 1);
  endtask

  task automatic request(input bit wr, input bit rd, input logic [5:0] a, input logic [3:0] n);
    i_wr_req = wr;
    i_rd_req = rd;
    i_addr = a;
    i_num_b = n;
    step;
    check("ack_pulse", 32'(o_ack), 1);
    i_wr_req = 0;
    i_rd_req = 0;
  endtask

  // base < 0 selects random data, otherwise bytes are base, base+1, ...
  task automatic write_burst(input logic [5:0] a, input logic [3:0] n, input int base,
                             input bit both, input int stall);
    int a0, d0;
    logic [7:0] d;
    a0 = ack_seen;
    d0 = done_seen;
    request(1, both, a, n);
    if (stall > 0) begin
      repeat (stall) step;
      check("stall_no_done", 32'(done_seen - d0), 0);
    end
    for (int i = 0; i < int'(n); i++) begin
      d = base >= 0 ? 8'(base + i) : 8'($urandom);
      i_wr_data = d;
      i_wr_valid = 1;
      step;
      wait_sig("wr_done", 0);
      model[(int'(a) + i) % 64] = d;
    end
    i_wr_valid = 0;
    step;
    step;
    check("wr_done_count", 32'(done_seen - d0), 32'(n));
    check("wr_ack_count", 32'(ack_seen - a0), 1);
    check("wr_no_rd_valid", 32'(o_rd_valid), 0);
  endtask

  task automatic read_burst(input logic [5:0] a, input logic [3:0] n);
    request(0, 1, a, n);
    for (int i = 0; i < int'(n); i++) begin
      wait_sig("rd_valid", 1);
      check("rd_data", 32'(o_rd_data), 32'(model[(int'(a) + i) % 64]));
      i_rd_done = 1;
      step;
      i_rd_done = 0;
      check("rd_valid_drop", 32'(o_rd_valid), 0);
    end
    step;
    check("rd_idle", 32'(o_rd_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = 0;
    #1 i_reset = 1;
    #1;
    check("rst_ack", 32'(o_ack), 0);
    check("rst_wr_done", 32'(o_wr_done), 0);
    check("rst_rd_valid", 32'(o_rd_valid), 0);
    check("rst_rd_data", 32'(o_rd_data), 0);
    step;
    step;
    i_reset = 0;
    step;
    read_burst(6'd0, 4'd3);
    write_burst(6'd0, 4'd3, 3, 0, 0);
    read_burst(6'd0, 4'd3);
    write_burst(6'd62, 4'd4, 8'hA0, 0, 0);
    read_burst(6'd62, 4'd4);
    read_burst(6'd0, 4'd2);
    write_burst(6'd20, 4'd1, 8'h5A, 1, 0);
    read_burst(6'd20, 4'd1);
    write_burst(6'd30, 4'd0, 0, 0, 0);
    read_burst(6'd29, 4'd3);
    write_burst(6'd40, 4'd2, -1, 0, 10);
    read_burst(6'd40, 4'd2);
    repeat (10) begin
      logic [5:0] ra;
      logic [3:0] rn;
      ra = 6'($urandom);
      rn = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) write_burst(ra, rn, -1, 0, 0);
      else read_burst(ra, rn);
    end
    write_burst(6'd10, 4'd4, 8'h11, 0, 0);
    request(0, 1, 6'd10, 4'd4);
    wait_sig("pre_rst_valid", 1);
    check("pre_rst_data", 32'(o_rd_data), 32'h11);
    #2 i_reset = 1;
    #1;
    check("mid_rst_ack", 32'(o_ack), 0);
    check("mid_rst_wr_done", 32'(o_wr_done), 0);
    check("mid_rst_rd_valid", 32'(o_rd_valid), 0);
    check("mid_rst_rd_data", 32'(o_rd_data), 0);
    for (int i = 0; i < 64; i++) model[i] = 0;
    step;
    step;
    i_reset = 0;
    step;
    read_burst(6'd10, 4'd4);
    read_burst(6'd62, 4'd4);
    read_burst(6'($urandom), 4'd8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_rw_controller.md
Name: mem_rw_controller

Overview:
- Single-port 64x8 on-chip byte memory with a request/ack front end and per-byte handshakes for burst writes and burst reads.
- Host issues a write or read request with a start address and byte count; the controller acks, then moves bytes one at a time.
- Sits between a simple host/sequencer and local storage; one transaction in flight at a time.

Parameters:
- DATA_W, 8, byte width of memory and data ports
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W = 64 entries
- CNT_W, 4, width of byte-count input

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_wr_req  in  1  write request (level, sampled in IDLE)
- i_wr_data  in  DATA_W  write byte
- i_wr_valid  in  1  i_wr_data holds a valid byte
- o_wr_done  out  1  one-cycle pulse: byte captured
- i_rd_req  in  1  read request (level, sampled in IDLE)
- o_rd_data  out  DATA_W  read byte
- o_rd_valid  out  1  o_rd_data valid
- i_rd_done  in  1  host has consumed o_rd_data
- i_addr  in  ADDR_W  start address, shared by read and write
- o_ack  out  1  one-cycle pulse: request accepted
- i_num_b  in  CNT_W  number of bytes to transfer, shared by read and write

Behaviour:
- Reset (async, high): state IDLE; o_ack, o_wr_done, o_rd_valid = 0; o_rd_data = 0; counters = 0; all 64 memory bytes cleared to 0.
- States: IDLE, ACK, WR_DATA, RD_DATA.
- IDLE:
  - On an edge with i_wr_req=1 or i_rd_req=1, latch i_addr, i_num_b and direction, then go to ACK.
  - Write wins if both requests are high.
- ACK:
  - o_ack=1 for exactly this one cycle.
  - Next state: WR_DATA or RD_DATA.
  - If the latched count is 0, return to IDLE instead; no byte is moved.
- WR_DATA:
  - On an edge with i_wr_valid=1 and o_wr_done=0: mem[(addr+cnt) mod 64] <= i_wr_data, cnt++, o_wr_done=1 next cycle.
  - o_wr_done is a registered one-cycle pulse; no capture occurs while o_wr_done=1, so the host must update data after seeing done.
  - Effective rate: at most one byte per 2 cycles.
  - After the byte where cnt reaches num_b, go to IDLE in the same edge; the final o_wr_done pulse still occurs.
  - i_wr_valid=0 stalls indefinitely.
- RD_DATA:
  - o_rd_data = mem[(addr+cnt) mod 64], registered; o_rd_valid=1.
  - On an edge with o_rd_valid=1 and i_rd_done=1: cnt++ and o_rd_valid drops for one cycle.
  - The next byte is then presented with o_rd_valid=1.
  - After the last byte is consumed, go to IDLE with o_rd_valid=0.
- Requests seen outside IDLE are ignored and not queued. A request still high on return to IDLE starts a new transaction.
- Address arithmetic is ADDR_W bits and wraps 63 -> 0.
- Reset mid-transaction aborts immediately. Bytes already written are cleared by the reset memory clear.
- One controller clock domain; all inputs are assumed synchronous to i_clk.

Optional Feature:
- Macro MEM_RW_BOUND_CHECK_EN.
- Defined:
  - Extra output o_err (1 bit, reset 0).
  - A request with i_addr + i_num_b > 64 is rejected: no o_ack, o_err=1 for one cycle, stay in IDLE.
- Undefined:
  - No o_err port; out-of-range bursts wrap modulo 64.

Decomposition:
- Package mem_rw_pkg: DATA_W/ADDR_W/CNT_W/DEPTH localparams, state enum (IDLE, ACK, WR_DATA, RD_DATA).
- Sub-module mem_rw_ram: DEPTH x DATA_W array with async clear, synchronous write enable, registered read. The controller FSM lives in mem_rw_controller.

Test Plan:
- Write burst: i_wr_req=1, i_addr=0, i_num_b=3 -> o_ack single pulse. Then i_wr_valid=1 with data 3, 4, 5, each changed after o_wr_done -> exactly 3 o_wr_done pulses; mem[0..2] = 3, 4, 5; FSM returns to IDLE.
- Read back: i_rd_req=1, i_addr=0, i_num_b=3, i_rd_done pulsed per o_rd_valid -> o_rd_data 3, 4, 5 in order; o_rd_valid low after the third byte.
- Wrap: write i_addr=62, i_num_b=4, data A0..A3 -> mem[62]=A0, mem[63]=A1, mem[0]=A2, mem[1]=A3. With MEM_RW_BOUND_CHECK_EN defined -> o_err pulse, no o_ack.
- Arbitration and zero count: i_wr_req=1 and i_rd_req=1 together -> write handled. i_num_b=0 -> o_ack pulse, no o_wr_done, back to IDLE.
- Stall and reset: hold i_wr_valid=0 for 10 cycles in WR_DATA -> no o_wr_done. Assert i_reset mid-burst -> all outputs 0 asynchronously; a later read of any address returns 0.
